// File: rtl/pattern_loader_pkg.sv
// -----------------------------------------------------------------------------
// pattern_loader_pkg
// Shared board geometry, word/position types and the start-pattern enum used
// by the pattern loader and its ROM.
//   pos_t     : cell coordinate wide enough for either board axis
//   addr_t    : board word address
//   data_t    : one board word (DATA_W cells, bit 0 = leftmost cell)
//   pattern_t : start pattern select (PAT_RANDOM only meaningful when the
//               loader is built with LOADER_RANDOM_EN)
// -----------------------------------------------------------------------------
package pattern_loader_pkg;

    localparam int BOARD_W = 512;
    localparam int BOARD_H = 512;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = $clog2(BOARD_W * BOARD_H / DATA_W);
    localparam int POS_W   = ($clog2(BOARD_W) > $clog2(BOARD_H)) ?
                             $clog2(BOARD_W) : $clog2(BOARD_H);

    // Height of the stamp window in rows.
    localparam int STAMP_H = 8;

    typedef logic [POS_W-1:0]  pos_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        PAT_CLEAR   = 2'd0,
        PAT_GLIDER  = 2'd1,
        PAT_BLINKER = 2'd2,
        PAT_RANDOM  = 2'd3
    } pattern_t;

endpackage

// File: rtl/pattern_loader_rom.sv
// -----------------------------------------------------------------------------
// pattern_rom
// Combinational 4 x 8 x 8 stamp lookup. Bit k of the returned row is the cell
// k columns to the right of the stamp origin.
//   pattern_i : pattern select
//   row_i     : stamp row 0..7
//   bits_o    : 8-bit stamp row
// PAT_CLEAR and PAT_RANDOM both return zero; random data is not produced here.
// -----------------------------------------------------------------------------
module pattern_rom
    import pattern_loader_pkg::*;
(
    input  pattern_t   pattern_i,
    input  logic [2:0] row_i,
    output logic [7:0] bits_o
);

    always_comb begin
        bits_o = 8'h00;
        case (pattern_i)
            PAT_GLIDER: begin
                case (row_i)
                    3'd0:    bits_o = 8'h02;
                    3'd1:    bits_o = 8'h04;
                    3'd2:    bits_o = 8'h07;
                    default: bits_o = 8'h00;
                endcase
            end
            PAT_BLINKER: begin
                case (row_i)
                    3'd1:    bits_o = 8'h07;
                    default: bits_o = 8'h00;
                endcase
            end
            default: bits_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/pattern_loader.sv
// -----------------------------------------------------------------------------
// pattern_loader
// Streams a start pattern into the logic write port of the board double
// buffer. Every board word is written exactly once per run, in increasing
// address order: an 8x8 stamp lands at the latched origin, all other words
// are zero.
//
// Ports
//   clk_in       : system clock
//   rst_in       : synchronous active-high reset
//   start_in     : one-cycle load request (ignored while busy_out is high)
//   pattern_in   : pattern select, sampled with start_in
//   origin_x_in  : stamp column (bits [2:0] ignored -> byte aligned)
//   origin_y_in  : stamp row
//   addr_w_out   : write word address
//   data_out     : write data
//   wr_en_out    : write strobe
//   busy_out     : high from start acceptance through the done cycle
//   done_out     : one-cycle completion pulse
//
// Build option
//   LOADER_RANDOM_EN : pattern 3 fills the board from a 32-bit Galois LFSR
//                      (taps 32,22,2,1), seeded only by reset. Without it,
//                      pattern 3 is identical to clear.
//
// Timing: start sampled in cycle 0 -> busy from cycle 1, writes in cycles
// 2..N+1, done_out in cycle N+2.
// -----------------------------------------------------------------------------
module pattern_loader #(
    parameter int BOARD_W = pattern_loader_pkg::BOARD_W,
    parameter int BOARD_H = pattern_loader_pkg::BOARD_H,
    parameter int DATA_W  = pattern_loader_pkg::DATA_W,
    parameter int ADDR_W  = pattern_loader_pkg::ADDR_W
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_in,
    input  logic [1:0]               pattern_in,
    input  pattern_loader_pkg::pos_t origin_x_in,
    input  pattern_loader_pkg::pos_t origin_y_in,
    output logic [ADDR_W-1:0]        addr_w_out,
    output logic [DATA_W-1:0]        data_out,
    output logic                     wr_en_out,
    output logic                     busy_out,
    output logic                     done_out
);

    import pattern_loader_pkg::*;

    localparam int N_WORDS = BOARD_W * BOARD_H / DATA_W;
    localparam int X_W     = $clog2(BOARD_W);
    localparam int Y_W     = $clog2(BOARD_H);
    localparam int DW_W    = $clog2(DATA_W);
    localparam int COL_W   = X_W - DW_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_WORDS - 1);
    localparam logic [X_W-1:0]    ALIGN_MASK = ~X_W'(7);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic [ADDR_W-1:0]  cnt_q;
    pattern_t           pat_q;
    logic [X_W-1:0]     ox_q;
    logic [Y_W-1:0]     oy_q;

    // Control FSM with the word counter and latched run configuration.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            pat_q   <= PAT_CLEAR;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        pat_q   <= pattern_t'(pattern_in);
                        ox_q    <= origin_x_in[X_W-1:0] & ALIGN_MASK;
                        oy_q    <= origin_y_in[Y_W-1:0];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic issue;
    assign issue = (state_q == S_RUN);

    // ---- stage 1: split counter into row/column, vertical offset, ROM read
    logic [Y_W-1:0]   row_y_d;
    logic [COL_W-1:0] col_d;
    logic [Y_W-1:0]   dy_d;
    logic [7:0]       rom_row_d;

    assign row_y_d = cnt_q[ADDR_W-1:COL_W];
    assign col_d   = cnt_q[COL_W-1:0];
    // Natural Y_W-bit wrap gives the modulo-BOARD_H distance from the origin.
    assign dy_d    = row_y_d - oy_q;

    pattern_rom u_rom (
        .pattern_i (pat_q),
        .row_i     (dy_d[2:0]),
        .bits_o    (rom_row_d)
    );

    logic               vld_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [Y_W-1:0]     dy_p1;
    logic [COL_W-1:0]   col_p1;
    logic [7:0]         row_p1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
        end
    end

    always_ff @(posedge clk_in) begin
        addr_p1 <= cnt_q;
        dy_p1   <= dy_d;
        col_p1  <= col_d;
        row_p1  <= rom_row_d;
    end

`ifdef LOADER_RANDOM_EN
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

    // Right-shifting Galois LFSR, taps 32,22,2,1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_next_d;
    logic [31:0] rnd_p1;

    assign lfsr_next_d = lfsr_step(lfsr_q);

    // Advances once per issued word of a random run; only reset reseeds it,
    // so consecutive random runs produce different boards.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lfsr_q <= LFSR_SEED;
        end else if (issue && (pat_q == PAT_RANDOM)) begin
            lfsr_q <= lfsr_next_d;
        end
    end

    always_ff @(posedge clk_in) begin
        rnd_p1 <= lfsr_next_d;
    end
`endif

    // ---- stage 2: stamp hit test and write port drive
    logic              stamp_hit;
    logic [DATA_W-1:0] stamp_word;

    assign stamp_hit  = (dy_p1 < Y_W'(STAMP_H)) &&
                        (col_p1 == ox_q[X_W-1:DW_W]);
    // Byte alignment keeps the 8-bit row inside a single word.
    assign stamp_word = DATA_W'(row_p1) << ox_q[DW_W-1:0];

    always_comb begin
        wr_en_out  = vld_p1;
        addr_w_out = '0;
        data_out   = '0;
        if (vld_p1) begin
            addr_w_out = addr_p1;
            if (stamp_hit) begin
                data_out = stamp_word;
            end
`ifdef LOADER_RANDOM_EN
            if (pat_q == PAT_RANDOM) begin
                data_out = DATA_W'(rnd_p1);
            end
`endif
        end
    end

    assign busy_out = busy_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_pattern_loader.sv
module tb_pattern_loader;

    localparam int N    = 8192;
    localparam int WPR  = 16;
    localparam int BH   = 512;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic [8:0]  ox = 9'd0;
    logic [8:0]  oy = 9'd0;
    logic [12:0] addr_w;
    logic [31:0] data;
    logic        wr_en, busy, done;

    pattern_loader dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .start_in    (start),
        .pattern_in  (pat),
        .origin_x_in (ox),
        .origin_y_in (oy),
        .addr_w_out  (addr_w),
        .data_out    (data),
        .wr_en_out   (wr_en),
        .busy_out    (busy),
        .done_out    (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int fail_prints = 0;

    // ---------------- behavioural board model ----------------
    logic [31:0] exp_mem [N];
    logic [31:0] m_lfsr = SEED;

    function automatic logic [7:0] stamp_row(input int p, input int r);
        if (p == 1) return (r == 0) ? 8'h02 : (r == 1) ? 8'h04 : (r == 2) ? 8'h07 : 8'h00;
        if (p == 2) return (r == 1) ? 8'h07 : 8'h00;
        return 8'h00;
    endfunction

    task automatic build_model(input int p, input int x, input int y);
        int xa;
        int yy;
        for (int i = 0; i < N; i++) exp_mem[i] = 32'h0;
`ifdef LOADER_RANDOM_EN
        if (p == 3) begin
            for (int i = 0; i < N; i++) begin
                m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
                exp_mem[i] = m_lfsr;
            end
        end else begin
`else
        begin
`endif
            xa = x - (x % 8);
            for (int r = 0; r < 8; r++) begin
                yy = (y + r) % BH;
                exp_mem[yy * WPR + xa / 32] = {24'h0, stamp_row(p, r)} << (xa % 32);
            end
        end
    endtask

    function automatic int count_nz();
        int n = 0;
        for (int i = 0; i < N; i++) if (exp_mem[i] != 32'h0) n++;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    // ---------------- cycle-level compare process ----------------
    bit trk = 1'b0;
    int cyc = 0;
    int abort_at = -1;
    int n_wr = 0;
    int n_done = 0;
    int done_cyc = -1;

    task automatic check_cycle();
        logic e_wr, e_busy, e_done;
        logic [12:0] e_addr;
        logic [31:0] e_data;
        bit bad;
        e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_addr = '0; e_data = '0;
        if (!(abort_at >= 0 && cyc > abort_at)) begin
            e_wr   = (cyc >= 2) && (cyc <= N + 1);
            e_busy = (cyc >= 1) && (cyc <= N + 2);
            e_done = (cyc == N + 2);
            if (e_wr) begin
                e_addr = 13'(cyc - 2);
                e_data = exp_mem[cyc - 2];
            end
        end
        bad = (wr_en !== e_wr) || (busy !== e_busy) || (done !== e_done);
        if (e_wr) bad = bad || (addr_w !== e_addr) || (data !== e_data);
        vectors++;
        if (bad) begin
            miscompares++;
            if (fail_prints < 30) begin
                fail_prints++;
                $display("FAIL cycle %0d (got/want): wr_en %b/%b busy %b/%b done %b/%b addr %0d/%0d data %h/%h",
                         cyc, wr_en, e_wr, busy, e_busy, done, e_done, addr_w, e_addr, data, e_data);
            end
        end
        if (wr_en === 1'b1) n_wr++;
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (trk) begin
            cyc++;
            check_cycle();
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int p, input int x, input int y,
                       input int extra_cyc, input int abort_cyc);
        int stop;
        stop = (abort_cyc >= 0) ? abort_cyc + 10 : N + 4;
        @(negedge clk);
        pat = 2'(p); ox = 9'(x); oy = 9'(y); start = 1'b1;
        cyc = 0; abort_at = -1; n_wr = 0; n_done = 0; done_cyc = -1; trk = 1'b1;
        while (cyc < stop) begin
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            pat = 2'($urandom); ox = 9'($urandom); oy = 9'($urandom);
            if (cyc == extra_cyc) start = 1'b1;
            if (cyc == abort_cyc) begin
                rst = 1'b1;
                abort_at = abort_cyc;
                m_lfsr = SEED;
            end
        end
        trk = 1'b0;
        rst = 1'b0;
        start = 1'b0;
        chk("write count", 32'(n_wr), (abort_cyc >= 0) ? 32'(abort_cyc - 1) : 32'(N));
        chk("done count", 32'(n_done), (abort_cyc >= 0) ? 32'd0 : 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int rx, ry, rp, rc;
        repeat (3) @(negedge clk);
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset addr", 32'(addr_w), 32'd0);
        chk("reset data", data, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Glider at (40,10)
        build_model(1, 40, 10);
        chk("model glider 161", exp_mem[161], 32'h0000_0200);
        chk("model glider 177", exp_mem[177], 32'h0000_0400);
        chk("model glider 193", exp_mem[193], 32'h0000_0700);
        chk("model glider nz", 32'(count_nz()), 32'd3);
        run(1, 40, 10, -1, -1);
        chk("glider done cycle", 32'(done_cyc), 32'd8194);

        // Vertical wrap
        build_model(1, 0, 510);
        chk("model wrap 8160", exp_mem[8160], 32'h02);
        chk("model wrap 8176", exp_mem[8176], 32'h04);
        chk("model wrap 0", exp_mem[0], 32'h07);
        run(1, 0, 510, -1, -1);

        // Low origin_x bits ignored
        build_model(2, 45, 0);
        chk("model blinker 17", exp_mem[17], 32'h0000_0700);
        chk("model blinker nz", 32'(count_nz()), 32'd1);
        run(2, 45, 0, -1, -1);

        // Second start while busy is ignored
        build_model(1, 200, 300);
        run(1, 200, 300, 500, -1);

        // Reset mid-run, then a normal run
        build_model(2, 100, 100);
        run(2, 100, 100, -1, 100);
        build_model(1, 40, 10);
        run(1, 40, 10, -1, -1);

        // Pattern 3 straight after reset
        @(negedge clk);
        rst = 1'b1;
        m_lfsr = SEED;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx = int'($urandom_range(0, 511));
        ry = int'($urandom_range(0, 511));
        build_model(3, rx, ry);
`ifdef LOADER_RANDOM_EN
        chk("model lfsr first", exp_mem[0], 32'hD650_8003);
`else
        chk("model pat3 nz", 32'(count_nz()), 32'd0);
`endif
        run(3, rx, ry, -1, -1);

        // Randomized run with a stray start during busy
        rp = int'($urandom_range(0, 2));
        rx = int'($urandom_range(0, 511));
        ry = int'($urandom_range(0, 511));
        rc = int'($urandom_range(2, N));
        build_model(rp, rx, ry);
        run(rp, rx, ry, rc, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
